lock_pipe_buffer: RTL
=====================

// Module: lock_pipe_buffer
// PURPOSE
//   Parametrised multi-stage pipeline buffer with valid/ready handshake, lock (stall) and flush.
//   Successor to the single-register lock buffer; sits between CPU pipeline stages.
//   Adds per-stage valid bits, bubble collapsing and backpressure.
//   Also adds a flush for branch/exception squash and an occupancy count.
// PARAMETERS
//   WIDTH      32  data width in bits (>=1)
//   DEPTH       2  number of register stages (>=1)
//   RESET_VAL   0  value loaded into every stage data register on reset
// PORTS
//   clk        in   1                     clock, rising edge
//   rst_n      in   1                     synchronous reset, active-low
//   in_data    in   WIDTH                 upstream data
//   in_valid   in   1                     upstream data valid
//   in_ready   out  1                     buffer accepts in_data this cycle
//   out_data   out  WIDTH                 data of last stage (stage DEPTH-1)
//   out_valid  out  1                     out_data valid
//   out_ready  in   1                     downstream accepts out_data
//   lock       in   1                     freeze all stages (stall)
//   flush      in   1                     invalidate all stages
//   occupancy  out  $clog2(DEPTH+1)       number of valid stages
// BEHAVIOUR
//   - Priority at each rising edge: rst_n=0 > flush=1 > lock=1 > normal operation.
//   - Reset: all valid bits 0, all data regs = RESET_VAL.
//     During and after reset: out_valid=0, occupancy=0, out_data=RESET_VAL.
//     in_ready=0 while rst_n=0.
//   - State: stage i holds {v[i], d[i]}. Stage 0 is loaded from input; stage i loads from stage i-1.
//   - Transfers: out_fire = out_valid & out_ready; in_fire = in_valid & in_ready.
//   - Stage advance: mv[DEPTH-1] = !lock & (!v[DEPTH-1] | out_ready).
//     mv[i] = !lock & (!v[i] | (mv[i+1] & v[i]))  (bubble collapsing).
//     An empty stage always accepts when unlocked.
//   - On mv[i]: v[i] <= v[i-1] (in_valid for i=0); d[i] <= d[i-1] (in_data for i=0).
//     Data is loaded only when the source is valid; otherwise d[i] holds.
//   - in_ready = rst_n & !flush & mv[0]. The ready chain is combinational from out_ready to in_ready.
//   - out_valid = v[DEPTH-1] & !lock; out_data = d[DEPTH-1] (registered, no combinational path from in_data).
//   - Latency: an item accepted at edge N reaches out_valid after edge N+DEPTH-1 with no backpressure.
//     Throughput is 1 item/cycle sustained.
//   - Lock: every v[i] and d[i] holds; in_ready=0; out_valid=0; out_data holds; occupancy unchanged.
//   - Flush: at the next edge all v[i] <= 0 and data regs hold; same-cycle input is not accepted (in_ready=0).
//     Flush overrides lock.
//   - Full: all v[i]=1 and out_ready=0 -> in_ready=0.
//     Full with out_ready=1 -> in_ready=1 (simultaneous push/pop), occupancy unchanged.
//   - Empty: out_valid=0; in_ready=1 when unlocked and not flushing.
//   - occupancy = popcount(v); it never exceeds DEPTH. It updates one cycle after the fire events.
//   - Reset mid-operation: all in-flight items are discarded, identical to power-on reset.
//     No output transfer is signalled that cycle.
//   - DEPTH=1: single register with pass-through ready; full throughput when out_ready=1.
// TESTING (WIDTH=8, DEPTH=2, RESET_VAL=8'hA5, clk period 10)
//   1. rst_n=0 for 2 edges, in_valid=1
//      -> out_valid=0, occupancy=0, out_data=8'hA5, in_ready=0; no item accepted.
//   2. out_ready=1; push 11,22,33 back-to-back
//      -> out_valid=1 with 11,22,33 on 3 consecutive cycles, one cycle after each accept; occupancy<=2.
//   3. out_ready=0; push 11,22,33
//      -> 11 and 22 accepted; in_ready=0 on 33; occupancy=2.
//      Then out_ready=1 -> 11, 22, then 33 out in order.
//   4. One item (44) in stage 1; lock=1 for 3 cycles
//      -> out_valid=0, out_data=44, in_ready=0, occupancy=1 throughout.
//      lock=0 with out_ready=1 -> 44 delivered once.
//   5. Buffer full (occupancy=2); flush=1, lock=1, in_valid=1 with 55 in the same cycle
//      -> next cycle occupancy=0, out_valid=0; 55 never appears.
//   6. Bubble collapse: out_ready=0; push 66, idle 1 cycle, push 77
//      -> occupancy=2, 66 in the last stage; out_ready=1 -> 66 then 77.
//      Then assert rst_n=0 mid-stream -> occupancy=0 next cycle.

Source files
------------

// File: rtl/lock_pipe_buffer.sv
// Multi-stage valid/ready pipeline buffer with stall (lock), squash (flush),
// bubble collapsing and an occupancy count.
module lock_pipe_buffer #(
   parameter int unsigned          WIDTH     = 32,
   parameter int unsigned          DEPTH     = 2,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH-1:0]               in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   input  logic                           lock,
   input  logic                           flush,
   output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]   v;
   logic [DEPTH-1:0]   v_next;
   logic [DEPTH-1:0]   mv;
   logic [DEPTH:0]     src_v;
   logic [WIDTH-1:0]   d     [DEPTH];
   logic [WIDTH-1:0]   src_d [DEPTH+1];
   logic [CW-1:0]      cnt_next;
   logic               hole;

   // Stage i advances when some stage at or above it is empty, or the tail drains.
   always_comb begin
      mv   = '0;
      hole = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         hole  = hole | ~v[i];
         mv[i] = ~lock & hole;
      end
   end

   // Source of each stage: stage 0 from the input port, stage i from stage i-1.
   always_comb begin
      src_v    = {v, in_valid};
      src_d[0] = in_data;
      for (int i = 0; i < int'(DEPTH); i++) begin
         src_d[i+1] = d[i];
      end
   end

   always_comb begin
      v_next   = v;
      cnt_next = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (mv[i]) begin
            v_next[i] = src_v[i];
         end
         cnt_next = cnt_next + CW'(v_next[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v         <= '0;
         occupancy <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d[i] <= RESET_VAL;
         end
      end else if (flush) begin
         v         <= '0;
         occupancy <= '0;
      end else begin
         v         <= v_next;
         occupancy <= cnt_next;
         // Data only moves with a valid source so empty slots keep their last value.
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (mv[i] && src_v[i]) begin
               d[i] <= src_d[i];
            end
         end
      end
   end

   assign in_ready  = rst_n & ~flush & mv[0];
   assign out_valid = rst_n & v[DEPTH-1] & ~lock;
   assign out_data  = d[DEPTH-1];

endmodule
